// File: rtl/cpu_pkg.sv
// Shared fetch-path types and reset constants.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000;

  // One buffered fetch: instruction plus the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read from registered storage,
// so a pushed entry becomes visible the cycle after the push.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // Storage and pointer update; flush wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Upstream credit accounting must never overfill the queue.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && (cnt == CNT_W'(DEPTH))));
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, issues sequential fetches under a credit limit,
// queues in-order responses for decode and discards stale responses after a redirect.
module fetch_queue_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned      INST_W   = cpu_pkg::INST_W,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [INST_W-1:0] dec_inst
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redir_sel;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_next;
  logic [CNT_W-1:0]  stale;
  logic [CNT_W-1:0]  count;
  logic              req_fire;
  logic              redirect;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;

  // Credit check: queued plus outstanding fetches never exceed the queue depth.
  assign imem_req_valid = !rst && (({1'b0, count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Exception redirect outranks branch; targets are word aligned.
  assign redirect  = exc_valid || br_valid;
  assign redir_sel = exc_valid ? exc_addr : br_addr;
  assign target    = redir_sel & ~ADDR_W'(3);

  assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  assign push           = imem_rsp_valid && (stale == '0);
  assign pop            = dec_valid && dec_ready;
  assign push_data.pc   = rsp_pc;
  assign push_data.inst = imem_rsp_data;

  // PC, response PC, outstanding and stale-response bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        pc     <= target;
        rsp_pc <= target;
        stale  <= inflight_next;
      end else begin
        if (req_fire) begin
          pc <= pc + ADDR_W'(4);
        end
        if (imem_rsp_valid) begin
          if (stale != '0) begin
            stale <= stale - CNT_W'(1);
          end else begin
            rsp_pc <= rsp_pc + ADDR_W'(4);
          end
        end
      end
    end
  end

  // Memory protocol and stale-counter sanity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (inflight == '0)));
      assert (stale <= inflight);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = head.pc;
  assign dec_inst  = head.inst;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a small in-order, fixed-latency memory model.
module tb_fetch_queue_unit;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic        br_valid;
  logic [31:0] br_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;

  int checks;
  int failures;
  int lat;
  int cyc;
  int n_fire;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_queue_unit dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_addr       (exc_addr),
    .br_valid       (br_valid),
    .br_addr        (br_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted request, then drive the next due response.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    #1;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (f) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat);
      n_fire++;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && (pend_addr.size() > 0) && (pend_due[0] <= cyc + 1)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_addr[0] ^ KEY;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    exc_valid      = 1'b0;
    br_valid       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend_addr.delete();
    pend_due.delete();
    tick();
    tick();
    rst    = 1'b0;
    n_fire = 0;
  endtask

  initial begin
    checks = 0; failures = 0; lat = 1; cyc = 0; n_fire = 0;
    rst = 1'b1; exc_valid = 1'b0; exc_addr = '0; br_valid = 1'b0; br_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'hBFC0_0000);

    // 1: sequential streaming, 1-cycle memory
    rst = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0", imem_req_addr, 32'hBFC0_0000);
    tick();
    chk("t1_addr1", imem_req_addr, 32'hBFC0_0004);
    chk("t1_no_fallthrough", 32'(dec_valid), 32'd0);
    tick();
    chk("t1_dec_valid", 32'(dec_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_dec_pc", dec_pc, 32'hBFC0_0000 + 32'(4 * i));
      chk("t1_dec_inst", dec_inst, (32'hBFC0_0000 + 32'(4 * i)) ^ KEY);
      chk("t1_req_addr", imem_req_addr, 32'hBFC0_0008 + 32'(4 * i));
      tick();
    end

    // 2: decode stalled, credit limit of 4, then a single pop frees one credit
    do_reset();
    dec_ready = 1'b0;
    repeat (8) tick();
    chk("t2_fires", 32'(n_fire), 32'd4);
    chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("t2_head_pc", dec_pc, 32'hBFC0_0000);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t2_head_after_pop", dec_pc, 32'hBFC0_0004);
    chk("t2_req_reopen", 32'(imem_req_valid), 32'd1);
    chk("t2_req_addr", imem_req_addr, 32'hBFC0_0010);
    repeat (4) tick();
    chk("t2_fires_after", 32'(n_fire), 32'd5);
    chk("t2_req_blocked2", 32'(imem_req_valid), 32'd0);

    // 3: 3-cycle memory, branch with 2 in flight
    do_reset();
    lat = 3; dec_ready = 1'b1; imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    chk("t3_pc_before", imem_req_addr, 32'hBFC0_0008);
    br_valid = 1'b1; br_addr = 32'h8000_0102;
    tick();
    br_valid = 1'b0;
    chk("t3_br_addr", imem_req_addr, 32'h8000_0100);
    chk("t3_flushed", 32'(dec_valid), 32'd0);
    imem_req_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_stale_dropped", 32'(dec_valid), 32'd0);
    tick();
    chk("t3_first_valid", 32'(dec_valid), 32'd1);
    chk("t3_first_pc", dec_pc, 32'h8000_0100);
    chk("t3_first_inst", dec_inst, 32'h8000_0100 ^ KEY);
    tick();
    chk("t3_second_pc", dec_pc, 32'h8000_0104);

    // 4/5: exception and branch together, with a response arriving and a request accepted
    do_reset();
    lat = 1; dec_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_queue_filled", 32'(dec_valid), 32'd1);
    exc_valid = 1'b1; exc_addr = 32'hBFC0_0380;
    br_valid  = 1'b1; br_addr  = 32'h0000_1000;
    tick();
    exc_valid = 1'b0; br_valid = 1'b0; dec_ready = 1'b1;
    chk("t4_exc_wins", imem_req_addr, 32'hBFC0_0380);
    chk("t4_flushed", 32'(dec_valid), 32'd0);
    tick();
    chk("t5_stale_dropped", 32'(dec_valid), 32'd0);
    tick();
    chk("t5_target_valid", 32'(dec_valid), 32'd1);
    chk("t5_target_pc", dec_pc, 32'hBFC0_0380);
    chk("t5_target_inst", dec_inst, 32'hBFC0_0380 ^ KEY);
    tick();
    chk("t5_next_pc", dec_pc, 32'hBFC0_0384);

    // 6: PC wrap, then reset mid-stream
    do_reset();
    dec_ready = 1'b1; imem_req_ready = 1'b0;
    br_valid = 1'b1; br_addr = 32'hFFFF_FFFC;
    tick();
    br_valid = 1'b0;
    chk("t6_pc_top", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    chk("t6_pc_wrap", imem_req_addr, 32'h0000_0000);
    tick();
    chk("t6_dec_top", dec_pc, 32'hFFFF_FFFC);
    chk("t6_addr_after_wrap", imem_req_addr, 32'h0000_0004);
    tick();
    chk("t6_dec_wrap", dec_pc, 32'h0000_0000);
    chk("t6_dec_wrap_inst", dec_inst, 32'h0000_0000 ^ KEY);
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    tick();
    chk("t6_rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_pc", imem_req_addr, 32'hBFC0_0000);
    chk("t6_rst_dec_pc", dec_pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_post_rst_req", 32'(imem_req_valid), 32'd1);
    chk("t6_post_rst_addr", imem_req_addr, 32'hBFC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
